// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract unit with valid/ready handshake.
//
// The WIDTH-bit carry chain is cut into STAGES equal slices of SW bits.
// Stage k adds operand slice k using the carry registered by stage k-1.
// Operand bits that have not been added yet move forward with the beat in
// skew registers. Finished result slices move forward in deskew registers.
// The last stage also registers the carry, overflow, zero and negative flags.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand beat present
//   in_ready   : unit accepts a beat this cycle (= !(out_valid && !out_ready))
//   a, b       : operands, WIDTH bits
//   sub        : 0 = a+b, 1 = a-b (computed as a + ~b + 1)
//   out_valid  : result beat present
//   out_ready  : consumer takes the result this cycle
//   sum        : result modulo 2^WIDTH
//   cout       : carry out of the MSB (for subtract: 1 iff a >= b unsigned)
//   ovf        : two's-complement overflow
//   zero       : sum == 0
//   neg        : sum[WIDTH-1]
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SW = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("adder_pipe: invalid WIDTH/STAGES combination");
  end

  logic w_stall;
  logic w_adv;

  // The whole pipe freezes when the output beat is not taken. No stage can
  // advance on its own, so the ready path depends only on the output side.
  assign w_stall  = out_valid & ~out_ready;
  assign w_adv    = ~w_stall;
  assign in_ready = ~w_stall;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    // Operand bits still to be added when a beat arrives at this stage, and
    // result bits already finished by the earlier stages.
    localparam int REM  = WIDTH - g * SW;
    localparam int DONE = g * SW;

    logic [REM-1:0]       w_a_in;
    logic [REM-1:0]       w_b_in;
    logic                 w_c_in;
    logic                 w_v_in;
    logic [SW-1:0]        w_sl;
    logic                 w_c_nx;
    logic [DONE+SW-1:0]   w_s_nx;

    logic                 r_v;
    logic                 r_c;
    logic [DONE+SW-1:0]   r_s;

    if (g == 0) begin : g_head
      // B is inverted once here and travels inverted. The subtract carry-in
      // enters as the stage-0 carry, so sub never has to travel further.
      assign w_a_in = a;
      assign w_b_in = sub ? ~b : b;
      assign w_c_in = sub;
      assign w_v_in = in_valid;
      assign w_s_nx = w_sl;
    end else begin : g_link
      assign w_a_in = g_stage[g-1].g_skew.r_a;
      assign w_b_in = g_stage[g-1].g_skew.r_b;
      assign w_c_in = g_stage[g-1].r_c;
      assign w_v_in = g_stage[g-1].r_v;
      assign w_s_nx = {w_sl, g_stage[g-1].r_s};
    end

    assign {w_c_nx, w_sl} = {1'b0, w_a_in[SW-1:0]}
                          + {1'b0, w_b_in[SW-1:0]}
                          + {{SW{1'b0}}, w_c_in};

    // Data registers load only for a real beat. A bubble leaves them as they
    // are, so the output holds its last values while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v_in;
        if (w_v_in) begin
          r_c <= w_c_nx;
          r_s <= w_s_nx;
        end
      end
    end

    if (g < STAGES - 1) begin : g_skew
      logic [REM-SW-1:0] r_a;
      logic [REM-SW-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_v_in) begin
          r_a <= w_a_in[REM-1:SW];
          r_b <= w_b_in[REM-1:SW];
        end
      end
    end else begin : g_tail
      logic w_ovf;
      logic r_ovf;
      logic r_zero;
      logic r_neg;

      // a ^ b' ^ s at the MSB recovers the carry into the MSB.
      // XOR with the carry out gives signed overflow.
      assign w_ovf = w_a_in[SW-1] ^ w_b_in[SW-1] ^ w_sl[SW-1] ^ w_c_nx;

      // The flags have their own registers so they read 0 after reset,
      // even though the reset sum of 0 would otherwise give zero = 1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
          r_neg  <= 1'b0;
        end else if (w_adv && w_v_in) begin
          r_ovf  <= w_ovf;
          r_zero <= (w_s_nx == '0);
          r_neg  <= w_s_nx[DONE+SW-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign sum       = g_stage[STAGES-1].r_s;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_tail.r_ovf;
  assign zero      = g_stage[STAGES-1].g_tail.r_zero;
  assign neg       = g_stage[STAGES-1].g_tail.r_neg;

endmodule
